// File: rtl/alu_exec_stage.sv
// alu_exec_stage: execute-stage ALU with one-hot op select.
// Non-shift ops complete in the same cycle. By default, shifts run on an
// iterative one-bit-per-cycle FSM (IDLE -> SHIFT -> DONE). While that FSM
// is busy, the block stalls upstream.
// Define ALU_FAST_SHIFT_EN to use a single-cycle barrel shifter instead.
// In that build the FSM never leaves IDLE and o_Stall_1 stays 0.
module alu_exec_stage (
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_Valid_1,
    input  logic        i_Flush_1,
    input  logic [11:0] i_ALUControl_12,
    input  logic [31:0] i_ALUOperand1_32,
    input  logic [31:0] i_ALUOperand2_32,
    input  logic [31:0] i_PCPlus4_32,
    input  logic        i_JumpBranch_1,
    output logic        o_Stall_1,
    output logic        o_Valid_1,
    output logic [31:0] o_Result_32,
    output logic        o_Zero_1
);

`ifdef ALU_FAST_SHIFT_EN
    localparam bit FAST_SHIFT = 1'b1;
`else
    localparam bit FAST_SHIFT = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
    typedef enum logic [1:0] {SK_SLL, SK_SRL, SK_SRA} shift_kind_e;

    state_e      state_q, state_d;
    shift_kind_e kind_q, kind_d, op_kind;
    logic [31:0] acc_q, acc_d, acc_shifted;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] alu_res;
    logic        op_is_shift;
    logic [4:0]  shamt;

    assign shamt = i_ALUOperand2_32[4:0];

    // Single-cycle result: the lowest set control bit selects the op.
    // NOTE: every variable driven here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        alu_res     = '0;
        op_is_shift = 1'b0;
        op_kind     = SK_SLL;
        if (i_ALUControl_12[0]) begin
            alu_res = i_ALUOperand1_32 + i_ALUOperand2_32;
        end else if (i_ALUControl_12[1]) begin
            alu_res = i_ALUOperand1_32 - i_ALUOperand2_32;
        end else if (i_ALUControl_12[2]) begin
            op_is_shift = 1'b1;
            op_kind     = SK_SLL;
            // Iterative build only takes this path for shamt == 0, where op1 is the answer.
            alu_res     = FAST_SHIFT ? (i_ALUOperand1_32 << shamt) : i_ALUOperand1_32;
        end else if (i_ALUControl_12[3]) begin
            alu_res = {31'd0, $signed(i_ALUOperand1_32) < $signed(i_ALUOperand2_32)};
        end else if (i_ALUControl_12[4]) begin
            alu_res = {31'd0, i_ALUOperand1_32 < i_ALUOperand2_32};
        end else if (i_ALUControl_12[5]) begin
            alu_res = i_ALUOperand1_32 ^ i_ALUOperand2_32;
        end else if (i_ALUControl_12[6]) begin
            op_is_shift = 1'b1;
            op_kind     = SK_SRL;
            alu_res     = FAST_SHIFT ? (i_ALUOperand1_32 >> shamt) : i_ALUOperand1_32;
        end else if (i_ALUControl_12[7]) begin
            op_is_shift = 1'b1;
            op_kind     = SK_SRA;
            alu_res     = FAST_SHIFT ? ($signed(i_ALUOperand1_32) >>> shamt) : i_ALUOperand1_32;
        end else if (i_ALUControl_12[8]) begin
            alu_res = i_ALUOperand1_32 | i_ALUOperand2_32;
        end else if (i_ALUControl_12[9]) begin
            alu_res = i_ALUOperand1_32 & i_ALUOperand2_32;
        end else if (i_ALUControl_12[10]) begin
            alu_res = i_ALUOperand2_32;
        end else if (i_ALUControl_12[11]) begin
            alu_res = i_PCPlus4_32;
        end
        // A jump/branch with LINK set always writes the link value.
        if (i_JumpBranch_1 && i_ALUControl_12[11]) begin
            alu_res     = i_PCPlus4_32;
            op_is_shift = 1'b0;
        end
    end

    // One-bit step of the latched shift, direction taken from latched state only.
    always_comb begin
        case (kind_q)
            SK_SLL:  acc_shifted = {acc_q[30:0], 1'b0};
            SK_SRL:  acc_shifted = {1'b0, acc_q[31:1]};
            default: acc_shifted = {acc_q[31], acc_q[31:1]};
        endcase
    end

    // Next-state and output decode for the shift FSM.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        kind_d      = kind_q;
        o_Stall_1   = 1'b0;
        o_Valid_1   = 1'b0;
        o_Result_32 = '0;
        case (state_q)
            IDLE: begin
                if (!i_Flush_1) begin
                    if (!FAST_SHIFT && i_Valid_1 && op_is_shift && (shamt != 5'd0)) begin
                        o_Stall_1 = 1'b1;
                        state_d   = SHIFT;
                        acc_d     = i_ALUOperand1_32;
                        cnt_d     = shamt;
                        kind_d    = op_kind;
                    end else begin
                        o_Valid_1   = i_Valid_1;
                        o_Result_32 = i_Valid_1 ? alu_res : '0;
                    end
                end
            end
            SHIFT: begin
                if (i_Flush_1) begin
                    state_d = IDLE;
                end else begin
                    o_Stall_1 = 1'b1;
                    acc_d     = acc_shifted;
                    cnt_d     = cnt_q - 5'd1;
                    if (cnt_q == 5'd1) state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (!i_Flush_1) begin
                    o_Valid_1   = 1'b1;
                    o_Result_32 = acc_q;
                end
            end
            default: state_d = IDLE;
        endcase
        // Outputs are quiet for as long as reset is held.
        if (!rstn) begin
            o_Stall_1   = 1'b0;
            o_Valid_1   = 1'b0;
            o_Result_32 = '0;
        end
        o_Zero_1 = o_Valid_1 && (o_Result_32 == 32'd0);
    end

    // FSM state, accumulator and counter registers.
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            kind_q  <= SK_SLL;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            kind_q  <= kind_d;
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: directed and random checks of alu_exec_stage.
// Expected results come from a behavioural ALU model. Shift latency is
// derived from the shift amount and from whether ALU_FAST_SHIFT_EN is
// defined.
module tb_alu_exec_stage;

`ifdef ALU_FAST_SHIFT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    localparam logic [11:0] OP_ADD  = 12'h001;
    localparam logic [11:0] OP_SLL  = 12'h004;
    localparam logic [11:0] OP_SLT  = 12'h008;
    localparam logic [11:0] OP_SLTU = 12'h010;
    localparam logic [11:0] OP_SRL  = 12'h040;
    localparam logic [11:0] OP_SRA  = 12'h080;
    localparam logic [11:0] OP_LINK = 12'h800;

    logic        clk = 1'b0;
    logic        rstn;
    logic        i_Valid_1, i_Flush_1, i_JumpBranch_1;
    logic [11:0] i_ALUControl_12;
    logic [31:0] i_ALUOperand1_32, i_ALUOperand2_32, i_PCPlus4_32;
    logic        o_Stall_1, o_Valid_1, o_Zero_1;
    logic [31:0] o_Result_32;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    alu_exec_stage dut (
        .clk              (clk),
        .rstn             (rstn),
        .i_Valid_1        (i_Valid_1),
        .i_Flush_1        (i_Flush_1),
        .i_ALUControl_12  (i_ALUControl_12),
        .i_ALUOperand1_32 (i_ALUOperand1_32),
        .i_ALUOperand2_32 (i_ALUOperand2_32),
        .i_PCPlus4_32     (i_PCPlus4_32),
        .i_JumpBranch_1   (i_JumpBranch_1),
        .o_Stall_1        (o_Stall_1),
        .o_Valid_1        (o_Valid_1),
        .o_Result_32      (o_Result_32),
        .o_Zero_1         (o_Zero_1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic expect_out(input string tag, input logic st, input logic vl, input logic [31:0] res);
        check({tag, " stall"}, {31'd0, o_Stall_1}, {31'd0, st});
        check({tag, " valid"}, {31'd0, o_Valid_1}, {31'd0, vl});
        check({tag, " result"}, o_Result_32, res);
        check({tag, " zero"}, {31'd0, o_Zero_1}, {31'd0, vl && (res == 32'd0)});
    endtask

    task automatic drive(input logic v, input logic fl, input logic [11:0] c,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic jb);
        i_Valid_1        = v;
        i_Flush_1        = fl;
        i_ALUControl_12  = c;
        i_ALUOperand1_32 = a;
        i_ALUOperand2_32 = b;
        i_PCPlus4_32     = pc;
        i_JumpBranch_1   = jb;
    endtask

    function automatic logic [11:0] rand_ctrl();
        logic [11:0] c;
        if ($urandom_range(3, 0) == 0) c = 12'($urandom);
        else c = 12'd1 << $urandom_range(11, 0);
        return c;
    endfunction

    // Behavioural ALU: find the winning op index, then compute the result arithmetically.
    task automatic ref_alu(input logic [11:0] c, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] pc, input logic jb,
                           output logic [31:0] r, output bit is_shift);
        int sel = -1;
        int s   = int'(b % 32);
        for (int i = 11; i >= 0; i--) if (c[i]) sel = i;
        r = 32'd0;
        is_shift = 1'b0;
        case (sel)
            0:  r = a + b;
            1:  r = a - b;
            2:  begin r = a << s; is_shift = 1'b1; end
            3:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4:  r = (a < b) ? 32'd1 : 32'd0;
            5:  r = a ^ b;
            6:  begin r = a >> s; is_shift = 1'b1; end
            7:  begin
                    r = a >> s;
                    if (a[31]) r = r | ~(32'hFFFF_FFFF >> s);
                    is_shift = 1'b1;
                end
            8:  r = a | b;
            9:  r = a & b;
            10: r = b;
            11: r = pc;
            default: r = 32'd0;
        endcase
        if (jb && c[11]) begin
            r = pc;
            is_shift = 1'b0;
        end
    endtask

    // Issue one instruction and follow it to its result, scrambling inputs while it is in flight.
    task automatic run_op(input string tag, input logic [11:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] pc, input logic jb);
        logic [31:0] exp;
        bit          sh;
        int          n;
        ref_alu(c, a, b, pc, jb, exp, sh);
        n = (sh && !FAST) ? int'(b % 32) : 0;
        @(negedge clk);
        drive(1'b1, 1'b0, c, a, b, pc, jb);
        #1;
        if (n == 0) begin
            expect_out(tag, 1'b0, 1'b1, exp);
        end else begin
            expect_out({tag, " start"}, 1'b1, 1'b0, 32'd0);
            for (int k = 0; k < n; k++) begin
                @(negedge clk);
                drive(1'b1, 1'b0, rand_ctrl(), $urandom, $urandom, $urandom, 1'($urandom));
                #1;
                expect_out({tag, " shifting"}, 1'b1, 1'b0, 32'd0);
            end
            @(negedge clk);
            drive(1'b1, 1'b0, rand_ctrl(), $urandom, $urandom, $urandom, 1'($urandom));
            #1;
            expect_out({tag, " done"}, 1'b0, 1'b1, exp);
        end
    endtask

    initial begin
        int pulses;
        drive(1'b1, 1'b0, OP_ADD, 32'd1, 32'd2, 32'd0, 1'b0);
        rstn = 1'b0;
        #12;
        expect_out("in_reset", 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        drive(1'b0, 1'b0, OP_ADD, 32'd0, 32'd0, 32'd0, 1'b0);
        rstn = 1'b1;
        #1;
        expect_out("after_reset", 1'b0, 1'b0, 32'd0);

        run_op("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
        run_op("slt", OP_SLT, 32'hFFFF_FFFE, 32'd1, 32'd0, 1'b0);
        run_op("sltu", OP_SLTU, 32'hFFFF_FFFE, 32'd1, 32'd0, 1'b0);
        run_op("sra4", OP_SRA, 32'h8000_0000, 32'd4, 32'd0, 1'b0);
        run_op("sll0", OP_SLL, 32'h1, 32'd0, 32'd0, 1'b0);
        run_op("srl28", OP_SRL, 32'hF000_0000, 32'd28, 32'd0, 1'b0);
        run_op("sll_upper_ignored", OP_SLL, 32'h0000_00A5, 32'hFFFF_FFE3, 32'd0, 1'b0);
        run_op("ctrl_zero", 12'h000, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 1'b0);
        run_op("lowest_bit_wins", 12'h220, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 1'b0);
        run_op("link", OP_LINK, 32'd7, 32'd9, 32'h0000_1004, 1'b1);
        run_op("jb_link_override", 12'h801, 32'd7, 32'd9, 32'h0000_2008, 1'b1);

        // Flush on an IDLE-cycle instruction kills it.
        @(negedge clk);
        drive(1'b1, 1'b1, OP_ADD, 32'd5, 32'd6, 32'd0, 1'b0);
        #1;
        expect_out("flush_idle", 1'b0, 1'b0, 32'd0);

`ifndef ALU_FAST_SHIFT_EN
        // SLL by 31, flushed on the third SHIFT cycle.
        @(negedge clk);
        drive(1'b1, 1'b0, OP_SLL, 32'h1, 32'd31, 32'd0, 1'b0);
        #1;
        expect_out("flush_sll start", 1'b1, 1'b0, 32'd0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #1;
            expect_out("flush_sll shifting", 1'b1, 1'b0, 32'd0);
        end
        @(negedge clk);
        i_Flush_1 = 1'b1;
        #1;
        expect_out("flush_sll flushed", 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        drive(1'b0, 1'b0, OP_ADD, 32'd0, 32'd0, 32'd0, 1'b0);
        #1;
        expect_out("flush_sll idle", 1'b0, 1'b0, 32'd0);
        run_op("after_flush_add", OP_ADD, 32'd40, 32'd2, 32'd0, 1'b0);

        // Flush landing on the DONE cycle suppresses the result.
        @(negedge clk);
        drive(1'b1, 1'b0, OP_SRL, 32'h8, 32'd2, 32'd0, 1'b0);
        #1;
        expect_out("flush_done start", 1'b1, 1'b0, 32'd0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #1;
        end
        @(negedge clk);
        i_Flush_1 = 1'b1;
        #1;
        expect_out("flush_done killed", 1'b0, 1'b0, 32'd0);

        // Reset in the middle of a shift: nothing emerges afterwards.
        @(negedge clk);
        drive(1'b1, 1'b0, OP_SLL, 32'h3, 32'd20, 32'd0, 1'b0);
        for (int k = 0; k < 3; k++) @(negedge clk);
        #1;
        check("pre_reset stall", {31'd0, o_Stall_1}, 32'd1);
        rstn = 1'b0;
        #1;
        expect_out("mid_shift_reset", 1'b0, 1'b0, 32'd0);
        i_Valid_1 = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        pulses = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            #1;
            if (o_Valid_1 || o_Stall_1) pulses++;
        end
        check("no_result_after_reset", 32'(pulses), 32'd0);
`endif

        for (int t = 0; t < 60; t++) begin
            run_op("random", rand_ctrl(), $urandom, $urandom, $urandom, 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_exec_stage.md
ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001 SHALL provide: clk  input  1  rising-edge clock.
REQ-002 SHALL provide: rstn  input  1  reset; rstn asynchronous, active-low; clock clk.
REQ-003 SHALL provide: i_Valid_1  input  1  instruction present in DE/ALU register.
REQ-004 SHALL provide: i_Flush_1  input  1  kill in-flight instruction (redirect).
REQ-005 SHALL provide: i_ALUControl_12  input  12  one-hot op: b0 ADD, b1 SUB, b2 SLL, b3 SLT, b4 SLTU, b5 XOR, b6 SRL, b7 SRA, b8 OR, b9 AND, b10 PASS2 (LUI), b11 LINK.
REQ-006 SHALL provide: i_ALUOperand1_32 / i_ALUOperand2_32  input  32 each  operands.
REQ-007 SHALL provide: i_PCPlus4_32  input  32  link value; i_JumpBranch_1  input  1  jump/branch marker.
REQ-008 SHALL provide: o_Stall_1  output  1  hold upstream stages and DE/ALU register.
REQ-009 SHALL provide: o_Valid_1  output  1  result valid this cycle.
REQ-010 SHALL provide: o_Result_32  output  32  result; o_Zero_1  output  1  (o_Result_32 == 0).

Function
REQ-011 Non-shift ops SHALL complete combinationally in the same cycle: o_Valid_1 = i_Valid_1 & ~i_Flush_1, o_Stall_1 = 0.
REQ-012 Arithmetic SHALL be 32-bit modulo 2^32; SLT signed, SLTU unsigned, result 32'h0/32'h1.
REQ-013 Shift amount SHALL be i_ALUOperand2_32[4:0]; upper operand bits ignored.
REQ-014 LINK, or i_JumpBranch_1 with b11, SHALL yield o_Result_32 = i_PCPlus4_32.
REQ-015 ALUControl = 0 SHALL yield result 0; multiple bits set: lowest set bit wins.
REQ-016 FSM states SHALL be IDLE, SHIFT, DONE; IDLE -> SHIFT when i_Valid_1 & shift op & shamt != 0 & ~i_Flush_1.
REQ-017 On IDLE->SHIFT the accumulator SHALL load operand1 and counter SHALL load shamt; o_Stall_1 = 1 combinationally in that IDLE cycle.
REQ-018 In SHIFT each cycle SHALL shift accumulator by 1 (SLL left, SRL zero-fill, SRA sign-fill) and decrement counter; counter == 1 -> DONE.
REQ-019 In SHIFT o_Stall_1 SHALL be 1 and o_Valid_1 SHALL be 0.
REQ-020 In DONE o_Valid_1 = 1, o_Result_32 = accumulator, o_Stall_1 = 0; next state IDLE unconditionally.
REQ-021 Shift with shamt = n >= 1 SHALL occupy n+2 cycles (1 IDLE, n SHIFT, 1 DONE); shamt = 0 SHALL complete as single-cycle op.
REQ-022 i_Flush_1 in any state SHALL force IDLE next edge, with o_Valid_1 = 0 and o_Stall_1 = 0 in that cycle.
REQ-023 When o_Valid_1 = 0, o_Result_32 SHALL be 0 and o_Zero_1 SHALL be 0.
REQ-024 Inputs changing during SHIFT SHALL NOT affect the in-flight shift (upstream holds; block relies only on latched state).

Reset
REQ-025 rstn low SHALL asynchronously force state IDLE, accumulator 0, counter 0.
REQ-026 During reset outputs SHALL be o_Stall_1 = 0, o_Valid_1 = 0, o_Result_32 = 0, o_Zero_1 = 0.
REQ-027 Reset asserted mid-shift SHALL abandon the shift; no result is produced after release.

Configuration
REQ-028 Macro ALU_FAST_SHIFT_EN defined: shifts SHALL use a single-cycle barrel shifter, FSM stays IDLE, o_Stall_1 constant 0.
REQ-029 ALU_FAST_SHIFT_EN undefined: iterative shift FSM of REQ-016..REQ-022 SHALL be built.

Verification
REQ-030 ADD 32'hFFFF_FFFF + 32'h1 -> same-cycle o_Result_32 = 0, o_Zero_1 = 1, o_Stall_1 = 0.
REQ-031 SLT op1 = 32'hFFFF_FFFE, op2 = 1 -> result 1; SLTU same operands -> result 0.
REQ-032 SRA op1 = 32'h8000_0000, shamt 4 (iterative) -> stall 5 cycles, then DONE with 32'hF800_0000, valid 1 cycle.
REQ-033 SLL op1 = 32'h1, shamt 0 -> result 32'h1 same cycle, no stall.
REQ-034 SLL shamt 31 with i_Flush_1 asserted on 3rd SHIFT cycle -> IDLE next edge, no valid pulse, stall drops.
REQ-035 With ALU_FAST_SHIFT_EN, SRL 32'hF000_0000 by 28 -> 32'h0000_000F same cycle, stall never asserted.
